// File: rtl/alu16_seq.sv
// Two-cycle 16-bit sequencer in front of the 8-bit ALU: low byte, then high byte
// with the carry/borrow chained. Returns the 16-bit result with Game Boy flags.
module alu16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op16,
  input  logic [15:0] lhs16,
  input  logic [15:0] rhs16,
  input  logic [3:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result16,
  output logic [3:0]  flags_out,
  output logic [7:0]  alu_lhs,
  output logic [7:0]  alu_rhs,
  output logic [3:0]  alu_op,
  output logic        alu_cf,
  input  logic [7:0]  alu_r,
  input  logic        alu_hf,
  input  logic        alu_cfo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LO   = 2'd1;
  localparam logic [1:0] HI   = 2'd2;

  localparam logic [1:0] OP_ADD16  = 2'b00;
  localparam logic [1:0] OP_ADDSP  = 2'b01;
  localparam logic [1:0] OP_INC16  = 2'b10;
  localparam logic [1:0] OP_DEC16  = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_ADC = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_SBC = 4'b0011;

  logic [1:0]  state_q,  state_d;
  logic [1:0]  op_q,     op_d;
  logic [15:0] lhs_q,    lhs_d;
  logic [15:0] rhs_q,    rhs_d;
  logic [3:0]  fin_q,    fin_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic        h_lo_q,   h_lo_d;
  logic        c_lo_q,   c_lo_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q,  flags_d;
  logic        done_q,   done_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    lhs_d    = lhs_q;
    rhs_d    = rhs_q;
    fin_d    = fin_q;
    res_lo_d = res_lo_q;
    h_lo_d   = h_lo_q;
    c_lo_d   = c_lo_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op16;
          lhs_d   = lhs16;
          rhs_d   = rhs16;
          fin_d   = flags_in;
          state_d = LO;
        end
      end
      LO: begin
        res_lo_d = alu_r;
        h_lo_d   = alu_hf;
        c_lo_d   = alu_cfo;
        state_d  = HI;
      end
      HI: begin
        result_d = {alu_r, res_lo_q};
        done_d   = 1'b1;
        state_d  = IDLE;
        // ADD HL keeps Z; ADD SP,e8 reports the low-byte carries; INC/DEC touch nothing.
        case (op_q)
          OP_ADD16: flags_d = {fin_q[3], 1'b0, alu_hf, alu_cfo};
          OP_ADDSP: flags_d = {1'b0, 1'b0, h_lo_q, c_lo_q};
          default:  flags_d = fin_q;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_lhs = 8'h00;
    alu_rhs = 8'h00;
    alu_op  = ALU_ADD;
    alu_cf  = 1'b0;
    case (state_q)
      LO: begin
        alu_lhs = lhs_q[7:0];
        alu_rhs = (op_q == OP_ADD16 || op_q == OP_ADDSP) ? rhs_q[7:0] : 8'h01;
        alu_op  = (op_q == OP_DEC16) ? ALU_SUB : ALU_ADD;
      end
      HI: begin
        alu_lhs = lhs_q[15:8];
        // e8 is sign-extended into the high byte.
        case (op_q)
          OP_ADD16: alu_rhs = rhs_q[15:8];
          OP_ADDSP: alu_rhs = {8{rhs_q[7]}};
          default:  alu_rhs = 8'h00;
        endcase
        alu_op  = (op_q == OP_DEC16) ? ALU_SBC : ALU_ADC;
        alu_cf  = c_lo_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      lhs_q    <= 16'h0000;
      rhs_q    <= 16'h0000;
      fin_q    <= 4'b0000;
      res_lo_q <= 8'h00;
      h_lo_q   <= 1'b0;
      c_lo_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 4'b0000;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      fin_q    <= fin_d;
      res_lo_q <= res_lo_d;
      h_lo_q   <= h_lo_d;
      c_lo_q   <= c_lo_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result16  = result_q;
  assign flags_out = flags_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Directed bench for alu16_seq; a behavioural 8-bit ALU answers the sequencer's
// drive so the 16-bit results and flags can be checked against hand values.
module tb_alu16_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op16;
  logic [15:0] lhs16, rhs16;
  logic [3:0]  flags_in;
  logic        busy, done;
  logic [15:0] result16;
  logic [3:0]  flags_out;
  logic [7:0]  alu_lhs, alu_rhs;
  logic [3:0]  alu_op;
  logic        alu_cf;
  logic [7:0]  alu_r;
  logic        alu_hf, alu_cfo;

  int totalChecks = 0;
  int badChecks   = 0;

  alu16_seq dut (
    .clk(clk), .rst(rst), .start(start), .op16(op16), .lhs16(lhs16), .rhs16(rhs16),
    .flags_in(flags_in), .busy(busy), .done(done), .result16(result16),
    .flags_out(flags_out), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs), .alu_op(alu_op),
    .alu_cf(alu_cf), .alu_r(alu_r), .alu_hf(alu_hf), .alu_cfo(alu_cfo)
  );

  always #5 clk = ~clk;

  // Reference 8-bit ALU: ADD/ADC report carries out of bits 3 and 7, SUB/SBC report borrows.
  logic [8:0] wide;
  logic [4:0] nib;
  always_comb begin
    wide    = 9'd0;
    nib     = 5'd0;
    alu_r   = 8'h00;
    alu_hf  = 1'b0;
    alu_cfo = 1'b0;
    case (alu_op)
      4'b0000, 4'b0001: begin
        wide    = {1'b0, alu_lhs} + {1'b0, alu_rhs} + {8'd0, (alu_op[0] & alu_cf)};
        nib     = {1'b0, alu_lhs[3:0]} + {1'b0, alu_rhs[3:0]} + {4'd0, (alu_op[0] & alu_cf)};
        alu_r   = wide[7:0];
        alu_hf  = nib[4];
        alu_cfo = wide[8];
      end
      4'b0010, 4'b0011: begin
        wide    = {1'b0, alu_lhs} - {1'b0, alu_rhs} - {8'd0, (alu_op[0] & alu_cf)};
        nib     = {1'b0, alu_lhs[3:0]} - {1'b0, alu_rhs[3:0]} - {4'd0, (alu_op[0] & alu_cf)};
        alu_r   = wide[7:0];
        alu_hf  = nib[4];
        alu_cfo = wide[8];
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns 1 ns after the accepting edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [15:0] lhs, input logic [15:0] rhs,
                               input logic [3:0] fin);
    @(negedge clk);
    start = 1'b1; op16 = op; lhs16 = lhs; rhs16 = rhs; flags_in = fin;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runOp(input string tag, input logic [1:0] op, input logic [15:0] lhs,
                       input logic [15:0] rhs, input logic [3:0] fin, input logic [15:0] expRes,
                       input logic [3:0] expFlags, input logic [3:0] expOpLo,
                       input logic [3:0] expOpHi, input logic expCfHi);
    applyStimulus(op, lhs, rhs, fin);
    checkOutput({tag, ".lo.busy"}, 16'(busy), 16'd1);
    checkOutput({tag, ".lo.op"},   16'(alu_op), 16'(expOpLo));
    checkOutput({tag, ".lo.lhs"},  16'(alu_lhs), 16'(lhs[7:0]));
    checkOutput({tag, ".lo.cf"},   16'(alu_cf), 16'd0);
    @(posedge clk); #1;
    checkOutput({tag, ".hi.busy"}, 16'(busy), 16'd1);
    checkOutput({tag, ".hi.done"}, 16'(done), 16'd0);
    checkOutput({tag, ".hi.op"},   16'(alu_op), 16'(expOpHi));
    checkOutput({tag, ".hi.cf"},   16'(alu_cf), 16'(expCfHi));
    checkOutput({tag, ".hi.lhs"},  16'(alu_lhs), 16'(lhs[15:8]));
    @(posedge clk); #1;
    checkOutput({tag, ".done"},    16'(done), 16'd1);
    checkOutput({tag, ".idle"},    16'(busy), 16'd0);
    checkOutput({tag, ".result"},  result16, expRes);
    checkOutput({tag, ".flags"},   16'(flags_out), 16'(expFlags));
    @(posedge clk); #1;
    checkOutput({tag, ".pulse"},   16'(done), 16'd0);
    checkOutput({tag, ".held"},    result16, expRes);
    checkOutput({tag, ".idledrv"}, {alu_lhs, alu_rhs}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op16 = 2'b00; lhs16 = 16'h0; rhs16 = 16'h0; flags_in = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.busy",   16'(busy), 16'd0);
    checkOutput("rst.done",   16'(done), 16'd0);
    checkOutput("rst.result", result16, 16'h0000);
    checkOutput("rst.flags",  16'(flags_out), 16'd0);
    checkOutput("rst.aluop",  16'(alu_op), 16'd0);
    rst = 1'b0;

    // op, lhs, rhs, flags_in, result, flags, alu_op LO/HI, carry into HI
    runOp("add16a", 2'b00, 16'h0FFF, 16'h0001, 4'b1001, 16'h1000, 4'b1010, 4'd0, 4'd1, 1'b1);
    runOp("add16b", 2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 4'd0, 4'd1, 1'b1);
    runOp("addspa", 2'b01, 16'h0005, 16'h00FE, 4'b0000, 16'h0003, 4'b0011, 4'd0, 4'd1, 1'b1);
    runOp("addspb", 2'b01, 16'h1000, 16'h0001, 4'b1111, 16'h1001, 4'b0000, 4'd0, 4'd1, 1'b0);
    runOp("inc16",  2'b10, 16'h00FF, 16'hBEEF, 4'b0101, 16'h0100, 4'b0101, 4'd0, 4'd1, 1'b1);
    runOp("dec16a", 2'b11, 16'h0000, 16'h1234, 4'b1010, 16'hFFFF, 4'b1010, 4'd2, 4'd3, 1'b1);
    runOp("dec16b", 2'b11, 16'h1234, 16'h0000, 4'b0001, 16'h1233, 4'b0001, 4'd2, 4'd3, 1'b0);
    runOp("incwrap",2'b10, 16'hFFFF, 16'h0000, 4'b0000, 16'h0000, 4'b0000, 4'd0, 4'd1, 1'b1);

    // start held high through LO/HI is ignored, then accepted again in the done cycle
    applyStimulus(2'b00, 16'h1111, 16'h2222, 4'b0000);
    start = 1'b1; op16 = 2'b10; lhs16 = 16'h0100; rhs16 = 16'h0000; flags_in = 4'b0110;
    checkOutput("hold.lo.busy", 16'(busy), 16'd1);
    @(posedge clk); #1;
    checkOutput("hold.hi.done", 16'(done), 16'd0);
    @(posedge clk); #1;
    checkOutput("hold.done",   16'(done), 16'd1);
    checkOutput("hold.result", result16, 16'h3333);
    checkOutput("hold.flags",  16'(flags_out), 16'd0);
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("b2b.busy",  16'(busy), 16'd1);
    checkOutput("b2b.done",  16'(done), 16'd0);
    @(posedge clk); #1;
    checkOutput("b2b.hi",    16'(busy), 16'd1);
    @(posedge clk); #1;
    checkOutput("b2b.done2", 16'(done), 16'd1);
    checkOutput("b2b.result", result16, 16'h0101);
    checkOutput("b2b.flags", 16'(flags_out), 16'b0110);

    // reset taken in HI aborts the operation with no done pulse
    applyStimulus(2'b00, 16'h0FFF, 16'h0001, 4'b1001);
    @(posedge clk); #1;
    checkOutput("abort.inhi", 16'(busy), 16'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort.busy",   16'(busy), 16'd0);
    checkOutput("abort.done",   16'(done), 16'd0);
    checkOutput("abort.result", result16, 16'h0000);
    checkOutput("abort.flags",  16'(flags_out), 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("abort.nodone", 16'(done), 16'd0);
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/alu16_seq.md
Name: alu16_seq

Overview:
- Two-cycle 16-bit arithmetic sequencer that sits directly upstream of the 8-bit combinational ALU and drives its operand, op and carry-in inputs.
- Executes 16-bit ops as low byte then high byte, using the ALU's ADD/ADC/SUB/SBC encodings.
- Chains the carry between the two bytes and returns the 16-bit result with Game Boy flag semantics to the CPU control path.
- Covers ADD HL,rr; ADD SP,e8 and LD HL,SP+e8; INC rr; DEC rr.

Parameters:
None.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
op16  input  2  operation: 00 ADD16, 01 ADD_SP_E8, 10 INC16, 11 DEC16
lhs16  input  16  first operand (HL or SP)
rhs16  input  16  second operand; for ADD_SP_E8 only rhs16[7:0] is used, as a signed e8; ignored for INC16/DEC16
flags_in  input  4  current {Z,N,H,C}
busy  output  1  high while an operation is in flight
done  output  1  one-cycle completion pulse
result16  output  16  result; valid from done, held until the next accepted start
flags_out  output  4  {Z,N,H,C}; valid and held like result16
alu_lhs  output  8  to ALU lhs
alu_rhs  output  8  to ALU rhs
alu_op  output  4  to ALU op
alu_cf  output  1  to ALU cf_in
alu_r  input  8  from ALU r
alu_hf  input  1  from ALU hf_out
alu_cfo  input  1  from ALU cf_out

Behaviour:
- Reset (rst=1 at an edge, in any state): state=IDLE; busy=0, done=0, result16=0x0000, flags_out=4'b0000, all latched operands cleared. A reset mid-operation aborts it; done is not asserted for the aborted operation.
- Start (IDLE and start=1): latch op16, lhs16, rhs16 and flags_in; go to LO. start is ignored in LO and HI (no queueing). start in the done cycle is accepted, because that cycle is IDLE.
- LO state: busy=1.
  - alu_lhs=lhs_q[7:0].
  - alu_rhs: rhs_q[7:0] for ADD16/ADD_SP_E8; 0x01 for INC16/DEC16.
  - alu_op: 0000 (ADD), except DEC16 uses 0010 (SUB). alu_cf=0.
  - At the edge: latch alu_r into res_lo, alu_hf into h_lo, alu_cfo into c_lo; go to HI.
- HI state: busy=1.
  - alu_lhs=lhs_q[15:8].
  - alu_rhs: rhs_q[15:8] for ADD16; {8{rhs_q[7]}} for ADD_SP_E8; 0x00 for INC16/DEC16.
  - alu_op: 0001 (ADC), except DEC16 uses 0011 (SBC). alu_cf=c_lo, which is the borrow for DEC16.
  - At the edge: result16={alu_r,res_lo}; set flags_out; done<=1; go to IDLE.
- Flags:
  - ADD16: Z=Z_in; N=0; H=HI alu_hf (carry out of bit 11); C=HI alu_cfo (carry out of bit 15).
  - ADD_SP_E8: Z=0; N=0; H=h_lo (carry out of bit 3); C=c_lo (carry out of bit 7).
  - INC16/DEC16: flags_out=flags_in latched at start (unchanged).
- Latency:
  - start sampled at edge E0.
  - busy is high in the cycles after E0 and after E1.
  - done is high for exactly the one cycle after E2.
  - Two cycles from acceptance to done.
- Idle drive: in IDLE, alu_lhs=alu_rhs=0x00, alu_op=0000, alu_cf=0.
- Width and wrap-around: all arithmetic is modulo 2^16. 0xFFFF+1 wraps to 0x0000; 0x0000-1 wraps to 0xFFFF.
- Outputs are registered, except the alu_* drive, which is decoded combinationally from state and latched operands.

Test Plan:
1. ADD16: lhs=0x0FFF, rhs=0x0001, flags_in=1001 -> result 0x1000, flags 1010; done exactly 2 cycles after accept; busy high for those 2 cycles.
2. ADD16: lhs=0xFFFF, rhs=0x0001, flags_in=0000 -> result 0x0000, flags 0011 (Z preserved at 0, H=1, C=1).
3. ADD_SP_E8: lhs=0x0005, rhs=0x00FE (e8=-2) -> result 0x0003, flags 0011. Then lhs=0x1000, rhs=0x0001 -> result 0x1001, flags 0000.
4. INC16 on 0x00FF -> 0x0100. DEC16 on 0x0000 with flags_in=1010 -> 0xFFFF, flags 1010 unchanged. Check alu_op 0010 then 0011 and alu_cf=1 in HI.
5. Start pulsed again during LO/HI -> ignored; single done; result from the first op. Back-to-back start in the done cycle is accepted.
6. rst asserted during HI -> next cycle busy=0, done=0, result16=0x0000, flags_out=0000; no done pulse follows.
